// File: rtl/scope_capture_ctrl.sv
// Scope acquisition sequencer: trigger arming, per-column decimating average, column handoff.
// Optional forced trigger after AUTO_TIMEOUT quiet samples when AUTO_TRIGGER_EN is defined.
module scope_capture_ctrl #(
  parameter int unsigned VAL_RES      = 16,
  parameter int unsigned NUM_COLS     = 640,
  parameter int unsigned COL_W        = 10,
  parameter int unsigned AUTO_TIMEOUT = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [VAL_RES-1:0] sample,
  input  logic               sample_valid,
  input  logic [VAL_RES-1:0] trig_level,
  input  logic               trig_falling,
  input  logic [2:0]         decim_log2,
  input  logic               col_ready,
  input  logic               frame_done,
  output logic [VAL_RES-1:0] col_val,
  output logic [COL_W-1:0]   col_idx,
  output logic               col_valid,
  output logic               armed,
  output logic               busy,
  output logic               overflow,
  output logic               auto_trig
);

  localparam int unsigned ACC_W = VAL_RES + 7;
  localparam int unsigned GRP_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VAL_RES-1:0] r_prev;
  logic               r_prev_valid;
  logic [ACC_W-1:0]   r_acc;
  logic [GRP_W-1:0]   r_grp_cnt;
  logic [2:0]         r_decim;
  logic [COL_W-1:0]   r_col_cnt;
  logic [VAL_RES-1:0] r_col_val;
  logic [COL_W-1:0]   r_col_idx;
  logic               r_col_valid;
  logic               r_armed;
  logic               r_busy;
  logic               r_overflow;
  logic               r_auto_trig;
  logic               r_fd_pend;

  logic               w_real_trig;
  logic               w_force_trig;
  logic               w_trig;
  logic               w_acc_en;
  logic [2:0]         w_decim;
  logic [ACC_W-1:0]   w_acc_base;
  logic [GRP_W-1:0]   w_grp_base;
  logic [GRP_W-1:0]   w_grp_max;
  logic [ACC_W-1:0]   w_sum;
  logic [VAL_RES-1:0] w_avg;
  logic               w_grp_last;
  logic               w_col_done;
  logic               w_out_free;
  logic               w_col_load;
  logic               w_col_last;
  logic               w_fd_seen;

  assign w_real_trig = sample_valid && r_prev_valid &&
                       (trig_falling ? (r_prev > trig_level && sample <= trig_level)
                                     : (r_prev < trig_level && sample >= trig_level));

`ifdef AUTO_TRIGGER_EN
  localparam int unsigned TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  assign w_force_trig = sample_valid && (r_to_cnt == TO_W'(AUTO_TIMEOUT));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (AUTO_TIMEOUT == 0);
  assign w_force_trig = 1'b0;
`endif

  // The trigger sample itself opens the first group, so it shares the accumulate path.
  assign w_trig     = (r_state == S_WAIT_TRIG) && (w_real_trig || w_force_trig);
  assign w_acc_en   = w_trig || ((r_state == S_CAPTURE) && sample_valid);
  assign w_decim    = (r_state == S_WAIT_TRIG) ? decim_log2 : r_decim;
  assign w_acc_base = (r_state == S_WAIT_TRIG) ? '0 : r_acc;
  assign w_grp_base = (r_state == S_WAIT_TRIG) ? '0 : r_grp_cnt;
  assign w_grp_max  = ~(7'h7F << w_decim);
  assign w_sum      = w_acc_base + ACC_W'(sample);
  assign w_avg      = VAL_RES'(w_sum >> w_decim);
  assign w_grp_last = (w_grp_base == w_grp_max);
  assign w_col_done = w_acc_en && w_grp_last;
  assign w_out_free = !r_col_valid || col_ready;
  assign w_col_load = w_col_done && w_out_free;
  assign w_col_last = (r_col_cnt == COL_W'(NUM_COLS - 1));
  assign w_fd_seen  = frame_done || r_fd_pend;

  // Next-state logic; dropping run overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (run) w_state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: if (w_trig) w_state_nxt = (w_col_load && w_col_last) ? S_HOLD : S_CAPTURE;
      S_CAPTURE:   if (w_col_load && w_col_last) w_state_nxt = S_HOLD;
      S_HOLD:      if (w_out_free && w_fd_seen) w_state_nxt = S_WAIT_TRIG;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (!run) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_acc        <= '0;
      r_grp_cnt    <= '0;
      r_decim      <= '0;
      r_col_cnt    <= '0;
      r_col_val    <= '0;
      r_col_idx    <= '0;
      r_col_valid  <= 1'b0;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
      r_auto_trig  <= 1'b0;
      r_fd_pend    <= 1'b0;
`ifdef AUTO_TRIGGER_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == S_WAIT_TRIG);
      r_busy  <= (w_state_nxt == S_CAPTURE) || (w_state_nxt == S_HOLD);

      if (r_col_valid && col_ready) r_col_valid <= 1'b0;
      if (w_col_load) begin
        r_col_val   <= w_avg;
        r_col_idx   <= r_col_cnt;
        r_col_valid <= 1'b1;
        r_col_cnt   <= r_col_cnt + COL_W'(1);
      end
      if (w_col_done && !w_out_free) r_overflow <= 1'b1;

      if (w_acc_en) begin
        if (w_grp_last) begin
          r_acc     <= '0;
          r_grp_cnt <= '0;
        end else begin
          r_acc     <= w_sum;
          r_grp_cnt <= w_grp_base + GRP_W'(1);
        end
      end
      if (w_trig) r_decim <= decim_log2;

      if ((r_state == S_WAIT_TRIG) && sample_valid) begin
        r_prev       <= sample;
        r_prev_valid <= 1'b1;
      end

`ifdef AUTO_TRIGGER_EN
      if (w_trig) r_auto_trig <= !w_real_trig;
      if ((w_state_nxt == S_WAIT_TRIG) && (r_state != S_WAIT_TRIG))
        r_to_cnt <= '0;
      else if ((r_state == S_WAIT_TRIG) && sample_valid && !w_force_trig)
        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif

      // frame_done is remembered until the last column has also been taken.
      if ((r_state == S_HOLD) && frame_done) r_fd_pend <= 1'b1;
      if ((r_state == S_HOLD) && (w_state_nxt == S_WAIT_TRIG)) begin
        r_prev_valid <= 1'b0;
        r_col_cnt    <= '0;
        r_overflow   <= 1'b0;
        r_fd_pend    <= 1'b0;
      end

      if (w_state_nxt == S_IDLE) begin
        r_col_valid  <= 1'b0;
        r_overflow   <= 1'b0;
        r_auto_trig  <= 1'b0;
        r_prev_valid <= 1'b0;
        r_acc        <= '0;
        r_grp_cnt    <= '0;
        r_col_cnt    <= '0;
        r_fd_pend    <= 1'b0;
      end
    end
  end

  assign col_val   = r_col_val;
  assign col_idx   = r_col_idx;
  assign col_valid = r_col_valid;
  assign armed     = r_armed;
  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign auto_trig = r_auto_trig;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: directed vectors, a column scoreboard fed by a sample-stream model,
// and literal checks. Exercises the forced-trigger path only when AUTO_TRIGGER_EN is defined.
module tb_scope_capture_ctrl;
  localparam int unsigned VR = 16;
  localparam int unsigned NC = 640;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst, run, sample_valid, trig_falling, col_ready, frame_done;
  logic [VR-1:0] sample, trig_level;
  logic [2:0]    decim_log2;
  logic [VR-1:0] col_val;
  logic [CW-1:0] col_idx;
  logic          col_valid, armed, busy, overflow, auto_trig;

  always #5 clk = ~clk;

  scope_capture_ctrl #(.VAL_RES(VR), .NUM_COLS(NC), .COL_W(CW), .AUTO_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .sample(sample), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_falling(trig_falling), .decim_log2(decim_log2),
    .col_ready(col_ready), .frame_done(frame_done), .col_val(col_val), .col_idx(col_idx),
    .col_valid(col_valid), .armed(armed), .busy(busy), .overflow(overflow), .auto_trig(auto_trig)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int idx; int val;} col_t;
  col_t exp_q[$];
  int   swp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    sample       = VR'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Expected columns from a fresh-armed sample stream: find the first edge crossing,
  // then average whole groups of 2^d samples starting at the trigger sample.
  task automatic model_push(input int s[$], input int lvl, input bit fall, input int d);
    int t, n, col, sum;
    t = -1;
    for (int i = 1; i < s.size(); i++) begin
      if (fall ? (s[i-1] > lvl && s[i] <= lvl) : (s[i-1] < lvl && s[i] >= lvl)) begin
        t = i;
        break;
      end
    end
    if (t < 0) return;
    n   = 1 << d;
    col = 0;
    for (int g = t; g + n <= s.size() && col < NC; g += n) begin
      sum = 0;
      for (int k = 0; k < n; k++) sum += s[g+k];
      exp_q.push_back('{col, sum >> d});
      col++;
    end
  endtask

  // Scoreboard on every transfer, plus stability of a stalled column.
  logic          pv = 1'b0;
  logic [VR-1:0] pval;
  logic [CW-1:0] pidx;
  always @(negedge clk) begin
    if (!rst && col_valid) begin
      if (pv) begin
        check("stall_val", col_val, pval);
        check("stall_idx", col_idx, pidx);
      end
      if (col_ready) begin
        check("col_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("col_idx", col_idx, exp_q[0].idx);
          check("col_val", col_val, exp_q[0].val);
          void'(exp_q.pop_front());
        end
      end
    end
    pv   <= !rst && col_valid && !col_ready;
    pval <= col_val;
    pidx <= col_idx;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b1; sample = '0; sample_valid = 1'b0; trig_level = '0;
    trig_falling = 1'b0; decim_log2 = '0; col_ready = 1'b0; frame_done = 1'b0;

    // Reset held with run high
    repeat (3) tick();
    check("rst_col_val", col_val, 0);
    check("rst_col_idx", col_idx, 0);
    check("rst_col_valid", col_valid, 0);
    check("rst_armed", armed, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_auto_trig", auto_trig, 0);
    trig_level = 16'd2048; trig_falling = 1'b0; decim_log2 = 3'd2; col_ready = 1'b1;
    rst = 1'b0;
    tick();
    check("rel_armed", armed, 1);
    check("rel_busy", busy, 0);

    // Rising trigger, 4-sample averaging
    swp = '{2000, 2040, 2060, 2100, 2140, 2180};
    model_push(swp, 2048, 1'b0, 2);
    send(2000); send(2040);
    check("rise_pre_armed", armed, 1);
    send(2060);
    check("rise_trig_armed", armed, 0);
    check("rise_trig_busy", busy, 1);
    send(2100); send(2140);
    check("rise_mid_valid", col_valid, 0);
    send(2180);
    check("rise_valid", col_valid, 1);
    check("rise_val", col_val, 2120);
    check("rise_idx", col_idx, 0);
    tick();
    check("rise_taken", col_valid, 0);
    run = 1'b0; tick();
    check("idle_armed", armed, 0);
    check("idle_busy", busy, 0);
    check("rise_q_empty", exp_q.size(), 0);

    // Falling trigger at exactly the level; 1200,1100 must not trigger
    trig_level = 16'd1000; trig_falling = 1'b1; decim_log2 = 3'd0;
    run = 1'b1; tick();
    send(1200); send(1100);
    check("fall_no_trig_armed", armed, 1);
    check("fall_no_trig_busy", busy, 0);
    run = 1'b0; tick(); run = 1'b1; tick();
    swp = '{1200, 1000};
    model_push(swp, 1000, 1'b1, 0);
    send(1200); send(1000);
    check("fall_busy", busy, 1);
    check("fall_valid", col_valid, 1);
    check("fall_val", col_val, 1000);
    tick();
    run = 1'b0; tick();
    check("fall_q_empty", exp_q.size(), 0);

    // Backpressure: second group discarded, overflow sticky until IDLE
    trig_level = 16'd100; trig_falling = 1'b0; decim_log2 = 3'd0; col_ready = 1'b0;
    run = 1'b1; tick();
    exp_q.push_back('{0, 150});
    exp_q.push_back('{1, 250});
    send(50); send(150);
    check("bp_first_valid", col_valid, 1);
    check("bp_first_ovf", overflow, 0);
    send(200);
    check("bp_held_val", col_val, 150);
    check("bp_held_idx", col_idx, 0);
    check("bp_ovf", overflow, 1);
    col_ready = 1'b1; tick();
    check("bp_drained", col_valid, 0);
    send(250);
    check("bp_next_idx", col_idx, 1);
    check("bp_next_val", col_val, 250);
    check("bp_ovf_sticky", overflow, 1);
    tick();
    run = 1'b0; tick();
    check("bp_ovf_cleared", overflow, 0);
    check("bp_q_empty", exp_q.size(), 0);

    // Full sweep, frame_done after last acceptance
    trig_level = 16'd10; trig_falling = 1'b0; decim_log2 = 3'd0; col_ready = 1'b1;
    swp = {};
    swp.push_back(0);
    for (int i = 0; i < int'(NC); i++) swp.push_back(20 + (i * 37) % 3000);
    run = 1'b1; tick();
    model_push(swp, 10, 1'b0, 0);
    for (int i = 0; i < swp.size(); i++) begin
      send(swp[i]);
      if (i == 300) check("sweep_mid_busy", busy, 1);
    end
    check("sweep_end_busy", busy, 1);
    check("sweep_end_armed", armed, 0);
    check("sweep_last_idx", col_idx, NC - 1);
    send(5000);
    check("hold_after_take_armed", armed, 0);
    check("hold_after_take_valid", col_valid, 0);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    check("rearm_armed", armed, 1);
    check("rearm_busy", busy, 0);
    check("sweep_q_empty", exp_q.size(), 0);

    // Second sweep, frame_done arrives before the last column is accepted
    model_push(swp, 10, 1'b0, 0);
    for (int i = 0; i < swp.size(); i++) send(swp[i]);
    col_ready = 1'b0;
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    tick();
    check("pend_armed", armed, 0);
    check("pend_busy", busy, 1);
    check("pend_valid", col_valid, 1);
    check("pend_idx", col_idx, NC - 1);
    col_ready = 1'b1; tick();
    check("pend_rearm", armed, 1);
    check("pend_taken", col_valid, 0);
    check("sweep2_q_empty", exp_q.size(), 0);

`ifdef AUTO_TRIGGER_EN
    // Forced trigger on the 17th constant sample, then run dropped mid-capture
    run = 1'b0; tick(); run = 1'b1; tick();
    trig_level = 16'd100; decim_log2 = 3'd1; col_ready = 1'b0;
    repeat (16) send(0);
    check("auto_wait_armed", armed, 1);
    check("auto_wait_flag", auto_trig, 0);
    send(0);
    check("auto_busy", busy, 1);
    check("auto_flag", auto_trig, 1);
    send(0);
    check("auto_col_valid", col_valid, 1);
    check("auto_col_val", col_val, 0);
    run = 1'b0; tick();
    check("auto_stop_valid", col_valid, 0);
    check("auto_stop_busy", busy, 0);
    check("auto_stop_flag", auto_trig, 0);
`else
    // Without the timeout a flat signal never triggers
    trig_level = 16'd100; decim_log2 = 3'd1;
    repeat (20) send(0);
    check("noauto_armed", armed, 1);
    check("noauto_flag", auto_trig, 0);
`endif

    // Reset wins over a coincident trigger
    run = 1'b1; col_ready = 1'b1; trig_level = 16'd100; tick();
    send(0);
    rst = 1'b1; sample = 16'd500; sample_valid = 1'b1; tick();
    sample_valid = 1'b0;
    check("rstwin_armed", armed, 0);
    check("rstwin_busy", busy, 0);
    check("rstwin_valid", col_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scope_capture_ctrl.md
# scope_capture_ctrl

Acquisition sequencer between the sample source and the frame-buffer write path of the HDMI scope. Arms on a level/edge trigger, decimates incoming samples into per-column averages, and hands exactly one value per screen column to the frame writer over a valid/ready handshake. After a full sweep it holds until the display signals a buffer swap, then re-arms.

## Interface
- VAL_RES, 16: sample width in bits
- NUM_COLS, 640: columns per sweep
- COL_W, 10: column index width (2^COL_W ≥ NUM_COLS)
- AUTO_TIMEOUT, 1048576: samples waited in WAIT_TRIG before forced trigger (AUTO_TRIGGER_EN only)

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- run  in  1  acquisition enable
- sample  in  VAL_RES  unsigned sample
- sample_valid  in  1  one-cycle strobe, sample valid
- trig_level  in  VAL_RES  trigger threshold
- trig_falling  in  1  0 = rising edge, 1 = falling edge
- decim_log2  in  3  samples per column = 2^decim_log2 (1..128)
- col_ready  in  1  frame writer accepts column
- frame_done  in  1  one-cycle pulse, display swapped buffers
- col_val  out  VAL_RES  averaged column value
- col_idx  out  COL_W  column index of col_val
- col_valid  out  1  column value pending
- armed  out  1  high in WAIT_TRIG
- busy  out  1  high in CAPTURE or HOLD
- overflow  out  1  sticky: a column group was discarded
- auto_trig  out  1  sticky: last trigger was forced (0 when macro absent)

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, HOLD. Reset → IDLE.
- IDLE: run=1 → WAIT_TRIG; clears overflow, auto_trig, prev_valid, accumulator, column counter.
- WAIT_TRIG: each accepted sample stored as prev; prev_valid set after first. Rising trigger: prev_valid && prev < trig_level && sample ≥ trig_level. Falling: prev_valid && prev > trig_level && sample ≤ trig_level. Trigger → CAPTURE; the triggering sample is the first accumulated sample.
- CAPTURE: accumulator width VAL_RES+7, unsigned. Group counter counts 2^decim_log2 samples; on the last sample, average = (acc + sample) >> decim_log2 (truncating), accumulator cleared.
  - Output register empty (col_valid=0 or col_ready=1 this cycle): load col_val, col_idx = column counter, col_valid=1, column counter +1.
  - Output register full and not accepted: group discarded, overflow=1, column counter unchanged.
  - Column counter reaching NUM_COLS → HOLD after the last column loads.
- HOLD: waits for last column accepted AND frame_done (frame_done before acceptance is remembered in a pending bit). Then → WAIT_TRIG, clearing prev_valid, column counter, overflow.
- decim_log2 sampled on entry to CAPTURE; changes mid-sweep ignored.
- frame_done outside HOLD ignored; trig_level/trig_falling read live in WAIT_TRIG only.
- run=0 in any state → IDLE next cycle; col_valid drops, pending column lost.

## Timing
- Reset values: col_val=0, col_idx=0, col_valid=0, armed=0, busy=0, overflow=0, auto_trig=0.
- Transfer occurs on a clk edge with col_valid && col_ready; col_val/col_idx stable while col_valid && !col_ready.
- Latency: col_valid asserts the cycle after the clk edge capturing a group's last sample.
- col_valid may stay high across a transfer if a new group completes in the same cycle (back-to-back).
- Transition into CAPTURE occurs on the edge sampling the trigger sample; armed drops, busy rises same edge.
- HOLD → WAIT_TRIG: one cycle after the later of final acceptance and frame_done.
- Simultaneous rst and any input: rst wins.

## Configuration
- AUTO_TRIGGER_EN defined: WAIT_TRIG counts accepted samples; at AUTO_TIMEOUT samples without trigger, forces trigger on the next sample, sets auto_trig (cleared on a real trigger or IDLE). Counter resets on entry to WAIT_TRIG.
- Undefined: no timeout counter; WAIT_TRIG waits indefinitely; auto_trig tied 0.

## Test plan
- Reset: assert rst 3 cycles with run=1 → all outputs 0, state IDLE; release → armed=1 next cycle.
- Rising trigger, level 2048, decim_log2=2: ramp 2000,2040,2060,2100,2140,2180 → trigger on 2060; first col_val=(2060+2100+2140+2180)>>2=2120, col_idx=0.
- Falling edge, level 1000: samples 1200,1000 → triggers on 1000; samples 1200,1100 never trigger.
- Backpressure: decim_log2=0, col_ready=0 for 2 samples → first value held, second discarded, overflow=1, next accepted col_idx=1.
- Full sweep NUM_COLS=640, col_ready=1: 640 columns idx 0..639, busy stays high; frame_done pulse → armed=1 one cycle later; frame_done before last acceptance still re-arms after acceptance.
- AUTO_TRIGGER_EN, AUTO_TIMEOUT=16, constant 0 samples: capture starts on 17th sample, auto_trig=1; run=0 mid-capture → IDLE, col_valid=0 next cycle.
